// File: rtl/cpu_pkg.sv
// Shared CPU constants: boot/exception vectors, nop encoding, ExcCodes, IF/ID state encoding.
// Also the fetch-exception bundle carried down the pipe.
package cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'hbfc00000;
  localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;
  localparam logic [31:0] NOP_INSTR  = 32'h0;

  localparam logic [4:0] EXC_INT  = 5'h0;
  localparam logic [4:0] ADEL     = 5'h4;
  localparam logic [4:0] ADES     = 5'h5;
  localparam logic [4:0] EXC_SYS  = 5'h8;
  localparam logic [4:0] EXC_BP   = 5'h9;
  localparam logic [4:0] EXC_RI   = 5'ha;
  localparam logic [4:0] EXC_OV   = 5'hc;

  localparam logic [0:0] IFID_STREAM = 1'b0;
  localparam logic [0:0] IFID_HOLD   = 1'b1;

  typedef struct packed {
    logic        exc;
    logic [31:0] badvaddr;
    logic [31:0] status;
    logic [30:0] cause;
  } exc_t;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry instruction hold buffer: passes SRAM read data through (0 cycles) in STREAM,
// replays the word captured on the first stall edge while stall_lu persists; flush/reset drop it.
module inst_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_lu,
  input  logic        flush,
  input  logic [31:0] rdata,
  output logic [31:0] instr
);

  logic [0:0]  state;
  logic [31:0] hold_instr;

  // The SRAM moves on to the next address during a stall, so the ID word is
  // only available from rdata in the first stalled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IFID_STREAM;
      hold_instr <= NOP_INSTR;
    end else if (flush) begin
      state <= IFID_STREAM;
    end else if (state == IFID_STREAM) begin
      if (stall_lu) begin
        hold_instr <= rdata;
        state      <= IFID_HOLD;
      end
    end else if (!stall_lu) begin
      state <= IFID_STREAM;
    end
  end

  assign instr = (state == IFID_HOLD) ? hold_instr : rdata;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: PC/exception bundle registered (1 cycle), instruction aligned from SRAM.
// Priority reset > flush > stall_lu > load; stall holds the slot, flush inserts a bubble.
module if_id_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_lu,
  input  logic        flush,
  input  logic [31:0] PC_if,
  input  logic [31:0] PC_1_if,
  input  logic        Exc_if,
  input  logic [31:0] BadVAddr_if,
  input  logic [31:0] Status_if,
  input  logic [30:0] Cause_if,
  input  logic [31:0] inst_sram_rdata,
  output logic        inst_sram_en,
  output logic        valid_id,
  output logic [31:0] PC_id,
  output logic [31:0] PC_1_id,
  output logic [31:0] Instr_id,
  output logic        Exc_id,
  output logic [31:0] BadVAddr_id,
  output logic [31:0] Status_id,
  output logic [30:0] Cause_id
);

  exc_t        exc_r;
  logic [31:0] aligned_instr;

  assign inst_sram_en = !reset && !Exc_if;

  // PC still loads on flush so a bubble carries a sensible EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_id <= 1'b0;
      PC_id    <= RESET_PC;
      PC_1_id  <= RESET_PC + 32'd4;
      exc_r    <= '0;
    end else if (flush) begin
      valid_id <= 1'b0;
      PC_id    <= PC_if;
      PC_1_id  <= PC_1_if;
      exc_r    <= '0;
    end else if (!stall_lu) begin
      valid_id       <= 1'b1;
      PC_id          <= PC_if;
      PC_1_id        <= PC_1_if;
      exc_r.exc      <= Exc_if;
      exc_r.badvaddr <= BadVAddr_if;
      exc_r.status   <= Status_if;
      exc_r.cause    <= Cause_if;
    end
  end

  inst_hold_buf u_hold (
    .clk      (clk),
    .reset    (reset),
    .stall_lu (stall_lu),
    .flush    (flush),
    .rdata    (inst_sram_rdata),
    .instr    (aligned_instr)
  );

  assign Exc_id      = valid_id && exc_r.exc;
  assign BadVAddr_id = valid_id ? exc_r.badvaddr : 32'h0;
  assign Status_id   = valid_id ? exc_r.status   : 32'h0;
  assign Cause_id    = valid_id ? exc_r.cause    : 31'h0;
  assign Instr_id    = (!valid_id || Exc_id) ? NOP_INSTR : aligned_instr;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage: expected ID slot contents are queued per edge
// and compared by an independent negedge monitor.
module tb_if_id_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall_lu = 1'b0, flush = 1'b0, Exc_if = 1'b0;
  logic [31:0] PC_if = 32'h0, PC_1_if = 32'h4, BadVAddr_if = 32'h0, Status_if = 32'h0;
  logic [30:0] Cause_if = 31'h0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        inst_sram_en, valid_id, Exc_id;
  logic [31:0] PC_id, PC_1_id, Instr_id, BadVAddr_id, Status_id;
  logic [30:0] Cause_id;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .reset(reset), .stall_lu(stall_lu), .flush(flush),
    .PC_if(PC_if), .PC_1_if(PC_1_if), .Exc_if(Exc_if), .BadVAddr_if(BadVAddr_if),
    .Status_if(Status_if), .Cause_if(Cause_if), .inst_sram_rdata(inst_sram_rdata),
    .inst_sram_en(inst_sram_en), .valid_id(valid_id), .PC_id(PC_id), .PC_1_id(PC_1_id),
    .Instr_id(Instr_id), .Exc_id(Exc_id), .BadVAddr_id(BadVAddr_id), .Status_id(Status_id),
    .Cause_id(Cause_id)
  );

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h24000000;
  endfunction

  // One-cycle-latency SRAM.
  always @(posedge clk)
    if (inst_sram_en) inst_sram_rdata <= mem_f(PC_if);

  typedef struct {
    logic        valid;
    logic [31:0] pc, pc1, instr;
    logic        exc;
    logic [31:0] bva, st;
    logic [30:0] cause;
  } exp_t;

  exp_t sb[$];
  int   total = 0, passed = 0;

  // Reference view of the ID slot: which PC it holds and what came with it.
  logic        m_valid = 1'b0, m_exc = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_pc1 = RESET_PC + 32'd4, m_bva = 32'h0, m_st = 32'h0;
  logic [30:0] m_cause = 31'h0;
  logic [31:0] fpc = RESET_PC;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic stl, input logic fl, input logic ex);
    exp_t e;
    reset = rst; stall_lu = stl; flush = fl; Exc_if = ex;
    PC_if = fpc; PC_1_if = fpc + 32'd4;
    BadVAddr_if = ex ? fpc : $urandom;
    Status_if = $urandom;
    Cause_if = ex ? {24'b0, ADEL, 2'b0} : 31'($urandom);
    #1 chk("inst_sram_en", {31'b0, inst_sram_en}, {31'b0, !rst && !ex});
    if (rst) begin
      m_valid = 0; m_pc = RESET_PC; m_pc1 = RESET_PC + 32'd4;
      m_exc = 0; m_bva = 0; m_st = 0; m_cause = 0;
      fpc = RESET_PC;
    end else if (fl) begin
      m_valid = 0; m_pc = PC_if; m_pc1 = PC_1_if;
      m_exc = 0; m_bva = 0; m_st = 0; m_cause = 0;
      fpc = {16'hbfc0, 14'($urandom), 2'b00};
    end else if (!stl) begin
      m_valid = 1; m_pc = PC_if; m_pc1 = PC_1_if;
      m_exc = Exc_if; m_bva = BadVAddr_if; m_st = Status_if; m_cause = Cause_if;
      fpc = fpc + 32'd4;
    end
    e.valid = m_valid;
    e.pc    = m_pc;
    e.pc1   = m_pc1;
    e.exc   = m_valid && m_exc;
    e.bva   = m_valid ? m_bva : 32'h0;
    e.st    = m_valid ? m_st : 32'h0;
    e.cause = m_valid ? m_cause : 31'h0;
    e.instr = (m_valid && !m_exc) ? mem_f(m_pc) : 32'h0;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("valid_id",    {31'b0, valid_id}, {31'b0, e.valid});
      chk("PC_id",       PC_id, e.pc);
      chk("PC_1_id",     PC_1_id, e.pc1);
      chk("Instr_id",    Instr_id, e.instr);
      chk("Exc_id",      {31'b0, Exc_id}, {31'b0, e.exc});
      chk("BadVAddr_id", BadVAddr_id, e.bva);
      chk("Status_id",   Status_id, e.st);
      chk("Cause_id",    {1'b0, Cause_id}, {1'b0, e.cause});
    end
  end

  initial begin
    @(posedge clk); #1;
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    // release from reset, sequential fetch
    drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    // three-cycle stall then release
    drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    // flush together with stall
    drive(0, 1, 0, 0); drive(0, 1, 1, 0);
    drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    // misaligned fetch exception
    fpc = 32'hbfc00002;
    drive(0, 0, 0, 1); drive(0, 0, 1, 0);
    drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    // reset in the second stall cycle
    drive(0, 1, 0, 0); drive(1, 1, 0, 0);
    drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    // back-to-back stall / release / stall
    drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    drive(0, 0, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic r_rst, r_fl, r_stl, r_ex;
      r_rst = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 11) == 0);
      r_stl = ($urandom_range(0, 2) == 0);
      r_ex  = ($urandom_range(0, 19) == 0);
      drive(r_rst, r_stl, r_fl, r_ex);
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline stage sitting directly downstream of instruction fetch. It latches the fetch-stage PC, PC+4 and fetch-exception bundle (AdEL), and presents the matching instruction word to decode. The instruction SRAM has one-cycle read latency, so the block aligns `inst_sram_rdata` with the latched PC. It keeps a hold buffer so the word survives `stall_lu` cycles. Flush squashes the slot to a bubble.

## Interface
- No parameters. Reset PC constant `RESET_PC = 32'hbfc00000` comes from the shared package.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `stall_lu` in 1: load-use stall; hold IF/ID contents.
- `flush` in 1: squash the instruction entering ID (redirect, Eret, Exc_mem/Exc_wr, Int_mem/Int_wr).
- `PC_if` in 32: current fetch PC, also the inst SRAM address.
- `PC_1_if` in 32: PC_if+4.
- `Exc_if` in 1: fetch exception flag.
- `BadVAddr_if` in 32: fetch-exception BadVAddr.
- `Status_if` in 32: fetch-exception Status.
- `Cause_if` in 31: fetch-exception Cause.
- `inst_sram_rdata` in 32: word for the address presented in the previous cycle.
- `inst_sram_en` out 1: fetch request enable; equals `!reset && !Exc_if`.
- `valid_id` out 1: ID slot holds a real instruction.
- `PC_id` out 32: PC of the ID instruction.
- `PC_1_id` out 32: PC+4 of the ID instruction.
- `Instr_id` out 32: instruction word; 0 (sll nop) when invalid or excepted.
- `Exc_id` out 1: exception bundle forwarded to ID.
- `BadVAddr_id` out 32: forwarded BadVAddr.
- `Status_id` out 32: forwarded Status.
- `Cause_id` out 31: forwarded Cause.

## Operation
- Per-edge priority for the pipeline register: reset > flush > stall_lu > load.
- Reset sets every registered output to 0, except `PC_id = RESET_PC` and `PC_1_id = RESET_PC+4`. Both valid flags clear and the state becomes STREAM.
- Flush loads a bubble: `valid_id=0`, `Exc_id=0`, exception fields 0, state STREAM. `PC_id`/`PC_1_id` still load from IF, so EPC stays sane.
- Load copies all `*_if` inputs into `*_id` and sets `valid_id=1`.
- Stall keeps all `*_id` registers unchanged.
- Instruction alignment state machine:
  - STREAM: `Instr_id = inst_sram_rdata`. On a stall edge, capture `inst_sram_rdata` into `hold_instr` and go to HOLD.
  - HOLD: `Instr_id = hold_instr`. Remain while `stall_lu`. Go to STREAM on the first non-stalled edge or on flush.
- Output masking: `Instr_id` is forced to 0 when `!valid_id` or `Exc_id`.
- `Exc_id` and its fields pass through only when `valid_id`. The fetch stage already suppresses `Exc_if` behind older exceptions; this block does not re-qualify it.
- A stall asserted while `valid_id=0` still holds the bubble. `hold_instr` is captured but masked.

## Timing
- Latency: PC_if=A in cycle t gives PC_id=A and Instr_id=mem[A] in cycle t+1 (combinational from rdata).
- First stall cycle t+1: output still comes from rdata. From t+2 onward it comes from `hold_instr`, even though the SRAM now returns mem[A+4].
- Release of the stall at edge e: the ID slot advances at e. The state is STREAM in the following cycle.
- Flush and stall in the same cycle: flush wins, with no hold.
- Reset mid-stall: the HOLD state is discarded.
- `inst_sram_en` is combinational; the SRAM address is `PC_if` unmodified.

## Structure
- Shared package `cpu_pkg` holds:
  - `RESET_PC` and `EXC_VECTOR` (`32'hbfc00380`).
  - `NOP_INSTR = 32'h0`.
  - Cause ExcCode constants (`ADEL = 5'h4`).
  - State encoding `IFID_STREAM`/`IFID_HOLD`.
- One natural sub-module, `inst_hold_buf`: the 1-entry hold register and the STREAM/HOLD FSM. The stage register stays in the top.

## Test plan
- Reset, then release with PC_if sequence bfc00000, bfc00004 and SRAM model latency 1 → cycle after release: `PC_id=bfc00000`, `Instr_id=mem[bfc00000]`, `valid_id=1`.
- Stall for 3 cycles with PC_id=A while the SRAM returns mem[A+4] → `Instr_id` stays mem[A` for all 3 cycles. After release, the next ID word is mem[A+4].
- Flush and stall together with ID at A → next cycle `valid_id=0`, `Instr_id=0`, state STREAM.
- PC_if=bfc00002, `Exc_if=1`, Cause_if={24'b0,5'h4,2'b0} → `inst_sram_en=0`. Next cycle `Exc_id=1`, `BadVAddr_id=bfc00002`, `Instr_id=0`.
- Reset asserted in the 2nd cycle of a stall → next cycle `valid_id=0`, `PC_id=bfc00000`, HOLD cleared. The first post-reset word comes from rdata.
- Back-to-back stall/release/stall → each stall captures the correct word, with no duplication or skipped PC.
